// File: rtl/apb_timer_pkg.sv
// apb_timer_pkg: register map, control/status bit positions, reset values and address decode.
package apb_timer_pkg;
  localparam logic [7:0] OFF_CTRL   = 8'h00;
  localparam logic [7:0] OFF_COUNT  = 8'h04;
  localparam logic [7:0] OFF_CMP    = 8'h08;
  localparam logic [7:0] OFF_STATUS = 8'h0C;
  localparam logic [7:0] OFF_PRESC  = 8'h10;
  localparam int CTRL_EN   = 0;
  localparam int CTRL_AR   = 1;
  localparam int CTRL_IE   = 2;
  localparam int STATUS_MF = 0;
  localparam logic [2:0]  CTRL_RST   = 3'b000;
  localparam logic        STATUS_RST = 1'b0;
  localparam logic [15:0] PRESC_RST  = 16'h0000;
  typedef enum logic [2:0] {R_CTRL, R_COUNT, R_CMP, R_STATUS, R_PRESC, R_NONE} reg_sel_e;
  function automatic reg_sel_e decode(input logic [31:0] a);
    return a == 32'(OFF_CTRL)   ? R_CTRL   :
           a == 32'(OFF_COUNT)  ? R_COUNT  :
           a == 32'(OFF_CMP)    ? R_CMP    :
           a == 32'(OFF_STATUS) ? R_STATUS :
           a == 32'(OFF_PRESC)  ? R_PRESC  : R_NONE;
  endfunction
endpackage

// File: rtl/apb_timer_presc.sv
// apb_timer_presc: emits one tick every div+1 enabled cycles; disabling or restarting clears the count.
module apb_timer_presc (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        restart,
  input  logic [15:0] div,
  output logic        tick
);
  logic [15:0] cnt_q, cnt_d;
  always_comb begin
    tick  = en & ~restart & (cnt_q == div);
    cnt_d = (!en || restart || tick) ? 16'h0000 : cnt_q + 16'd1;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= 16'h0000;
    else        cnt_q <= cnt_d;
endmodule

// File: rtl/apb_timer.sv
// apb_timer: APB-programmable up-counter with compare match, auto-reload and level interrupt.
// Optional prescaler enabled by defining APB_TIMER_PRESC_EN.
module apb_timer
  import apb_timer_pkg::*;
#(
  parameter int a_w   = 8,
  parameter int cnt_w = 32
) (
  input  logic           pclk,
  input  logic           presetn,
  input  logic [a_w-1:0] paddr,
  input  logic [31:0]    pwdata,
  output logic [31:0]    prdata,
  input  logic           pwrite,
  input  logic           psel,
  input  logic           penable,
  output logic           pready,
  output logic           irq
);
  reg_sel_e         sel;
  logic             wr, rd_setup, cnt_wr, tick, match;
  logic [2:0]       ctrl_q, ctrl_d;
  logic [cnt_w-1:0] count_q, count_d, cmp_q, cmp_d;
  logic             mf_q, mf_d;
  logic [31:0]      prdata_q, prdata_d, rd_data;
  logic [15:0]      presc_rd;
  logic             unused_ok;
  assign unused_ok = ^{pwdata, paddr[1:0]};
  assign sel      = decode(32'({paddr[a_w-1:2], 2'b00}));
  assign wr       = psel & penable & pwrite;
  assign rd_setup = psel & ~penable & ~pwrite;
  assign pready   = psel & penable;
  assign prdata   = prdata_q;
  assign irq      = mf_q & ctrl_q[CTRL_IE];
`ifdef APB_TIMER_PRESC_EN
  logic [15:0] presc_q, presc_d;
  logic        presc_wr, presc_tick;
  assign presc_wr = wr && sel == R_PRESC;
  assign presc_d  = presc_wr ? pwdata[15:0] : presc_q;
  assign presc_rd = presc_q;
  assign tick     = ctrl_q[CTRL_EN] & presc_tick;
  apb_timer_presc u_presc (
    .clk     (pclk),
    .rst_n   (presetn),
    .en      (ctrl_q[CTRL_EN]),
    .restart (presc_wr),
    .div     (presc_q),
    .tick    (presc_tick)
  );
  always_ff @(posedge pclk or negedge presetn)
    if (!presetn) presc_q <= PRESC_RST;
    else          presc_q <= presc_d;
`else
  assign presc_rd = 16'h0000;
  assign tick     = ctrl_q[CTRL_EN];
`endif
  always_comb begin
    cnt_wr   = wr && sel == R_COUNT;
    match    = tick & ~cnt_wr & (count_q == cmp_q);
    ctrl_d   = (wr && sel == R_CTRL) ? pwdata[2:0] : ctrl_q;
    cmp_d    = (wr && sel == R_CMP) ? pwdata[cnt_w-1:0] : cmp_q;
    count_d  = cnt_wr ? pwdata[cnt_w-1:0] :
               !tick ? count_q :
               (match && ctrl_q[CTRL_AR]) ? '0 : count_q + cnt_w'(1);
    // a match in the same cycle as a W1C wins, so no event is lost
    mf_d     = match | (mf_q & ~(wr && sel == R_STATUS && pwdata[STATUS_MF]));
    rd_data  = sel == R_CTRL   ? 32'(ctrl_q)   :
               sel == R_COUNT  ? 32'(count_q)  :
               sel == R_CMP    ? 32'(cmp_q)    :
               sel == R_STATUS ? 32'(mf_q)     :
               sel == R_PRESC  ? 32'(presc_rd) : 32'h0;
    prdata_d = rd_setup ? rd_data : prdata_q;
  end
  always_ff @(posedge pclk or negedge presetn)
    if (!presetn) begin
      ctrl_q   <= CTRL_RST;
      count_q  <= '0;
      cmp_q    <= '0;
      mf_q     <= STATUS_RST;
      prdata_q <= 32'h0;
    end else begin
      ctrl_q   <= ctrl_d;
      count_q  <= count_d;
      cmp_q    <= cmp_d;
      mf_q     <= mf_d;
      prdata_q <= prdata_d;
    end
endmodule

// File: tb/tb_apb_timer.sv
// tb_apb_timer: directed APB vectors with hand-computed expectations; t counts cycles since CTRL enable.
module tb_apb_timer;
  logic        pclk = 1'b0, presetn = 1'b0;
  logic [7:0]  paddr = 8'h00;
  logic [31:0] pwdata = 32'h0, prdata;
  logic        pwrite = 1'b0, psel = 1'b0, penable = 1'b0, pready, irq;
  int          n_chk = 0, n_pass = 0, t = 0;
  always #5 pclk = ~pclk;
  apb_timer #(.a_w(8), .cnt_w(8)) dut (
    .pclk(pclk), .presetn(presetn), .paddr(paddr), .pwdata(pwdata), .prdata(prdata),
    .pwrite(pwrite), .psel(psel), .penable(penable), .pready(pready), .irq(irq)
  );
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask
  task automatic idle(input int n);
    repeat (n) @(negedge pclk);
    t += n;
  endtask
  task automatic apb_wr(input logic [7:0] a, input logic [31:0] d);
    paddr = a; pwdata = d; pwrite = 1'b1; psel = 1'b1; penable = 1'b0;
    @(negedge pclk);
    penable = 1'b1;
    @(negedge pclk);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    t += 2;
  endtask
  task automatic rd_chk(input string tag, input logic [7:0] a, input logic [31:0] exp);
    paddr = a; pwrite = 1'b0; psel = 1'b1; penable = 1'b0;
    @(negedge pclk);
    penable = 1'b1;
    #1;
    chk({tag, "_pready"}, {31'h0, pready}, 32'h1);
    chk(tag, prdata, exp);
    @(negedge pclk);
    psel = 1'b0; penable = 1'b0;
    t += 2;
  endtask
  task automatic reset_dut;
    presetn = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    repeat (2) @(negedge pclk);
    presetn = 1'b1;
    t = 0;
  endtask
  function automatic int presc_cnt(input int c);
`ifdef APB_TIMER_PRESC_EN
    return c / 4;
`else
    return c;
`endif
  endfunction
  initial begin
    @(negedge pclk);
    chk("rst_irq", {31'h0, irq}, 32'h0);
    chk("rst_prdata", prdata, 32'h0);
    chk("rst_pready", {31'h0, pready}, 32'h0);
    reset_dut;
    chk("post_rst_irq", {31'h0, irq}, 32'h0);
    rd_chk("post_rst_count", 8'h04, 32'h0);
    apb_wr(8'h14, 32'hFFFF_FFFF);
    rd_chk("unmapped", 8'h14, 32'h0);
    // auto-reload: 0..5 repeating, MF on the tick where COUNT==5
    apb_wr(8'h08, 32'd5);
    apb_wr(8'h00, 32'h3);
    t = 0;
    idle(3);
    rd_chk("ar_count_a", 8'h04, 32'(t % 6));
    rd_chk("ar_mf_before", 8'h0C, 32'h0);
    rd_chk("ar_mf_after", 8'h0C, 32'h1);
    rd_chk("ar_count_b", 8'h04, 32'(t % 6));
    idle(1);
    rd_chk("ar_count_wrap", 8'h04, 32'(t % 6));
    chk("ar_irq_masked", {31'h0, irq}, 32'h0);
    rd_chk("ar_ctrl", 8'h00, 32'h3);
    // one-shot match with interrupt, then W1C
    reset_dut;
    apb_wr(8'h08, 32'd3);
    apb_wr(8'h00, 32'h5);
    t = 0;
    idle(3);
    chk("irq_before", {31'h0, irq}, 32'h0);
    idle(1);
    chk("irq_rise", {31'h0, irq}, 32'h1);
    apb_wr(8'h0C, 32'h1);
    chk("irq_w1c", {31'h0, irq}, 32'h0);
    rd_chk("noar_count_a", 8'h04, 32'(t));
    idle(2);
    rd_chk("noar_count_b", 8'h04, 32'(t));
    // natural wrap without a match
    reset_dut;
    apb_wr(8'h08, 32'h10);
    apb_wr(8'h04, 32'hFF);
    apb_wr(8'h00, 32'h1);
    t = 0;
    idle(1);
    rd_chk("wrap_count", 8'h04, 32'h0);
    rd_chk("wrap_mf", 8'h0C, 32'h0);
    // W1C coincident with match; COUNT write coincident with tick
    reset_dut;
    apb_wr(8'h08, 32'd3);
    apb_wr(8'h00, 32'h1);
    t = 0;
    idle(2);
    apb_wr(8'h0C, 32'h1);
    rd_chk("mf_set_wins", 8'h0C, 32'h1);
    apb_wr(8'h0C, 32'h1);
    rd_chk("mf_cleared", 8'h0C, 32'h0);
    apb_wr(8'h04, 32'h40);
    rd_chk("count_wr_wins", 8'h04, 32'h40);
    // prescaler
    reset_dut;
    apb_wr(8'h10, 32'h3);
`ifdef APB_TIMER_PRESC_EN
    rd_chk("presc_rd", 8'h10, 32'h3);
`else
    rd_chk("presc_rd", 8'h10, 32'h0);
`endif
    apb_wr(8'h00, 32'h1);
    t = 0;
    idle(3);
    rd_chk("presc_count_a", 8'h04, 32'(presc_cnt(t)));
    idle(3);
    rd_chk("presc_count_b", 8'h04, 32'(presc_cnt(t)));
    // reset during an access phase
    reset_dut;
    apb_wr(8'h04, 32'h20);
    apb_wr(8'h08, 32'h20);
    apb_wr(8'h00, 32'h5);
    idle(1);
    chk("pre_rst_irq", {31'h0, irq}, 32'h1);
    rd_chk("pre_rst_count", 8'h04, 32'h21);
    paddr = 8'h08; pwdata = 32'h55; pwrite = 1'b1; psel = 1'b1; penable = 1'b0;
    @(negedge pclk);
    penable = 1'b1;
    presetn = 1'b0;
    #1;
    chk("mid_rst_irq", {31'h0, irq}, 32'h0);
    chk("mid_rst_prdata", prdata, 32'h0);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    #1;
    chk("mid_rst_pready", {31'h0, pready}, 32'h0);
    @(negedge pclk);
    presetn = 1'b1;
    rd_chk("mid_rst_count", 8'h04, 32'h0);
    rd_chk("mid_rst_cmp", 8'h08, 32'h0);
    rd_chk("mid_rst_ctrl", 8'h00, 32'h0);
    rd_chk("mid_rst_status", 8'h0C, 32'h0);
    chk("mid_rst_irq_after", {31'h0, irq}, 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
